div_seq: RTL
============

# div_seq

Sequential 32-bit integer divider, the companion of the single-cycle `mul` array in the arithmetic unit. It computes quotient and remainder of `din1 / din2` using radix-2 restoring division, one quotient bit per clock. Signed and unsigned operation are both supported. Results follow RISC-V M-extension semantics. A start/busy/done handshake lets the surrounding datapath stall on it.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width. Only 32 is verified.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a division. Accepted only while `busy`=0.
- `sign`  in  1: 1 = signed (two's complement) operands; 0 = unsigned. Sampled with `start`.
- `din1`  in  WIDTH: dividend. Sampled with `start`.
- `din2`  in  WIDTH: divisor. Sampled with `start`.
- `busy`  out  1: high from the accepting edge until the result is written.
- `done`  out  1: one-cycle pulse when `quot`/`rem` become valid.
- `quot`  out  WIDTH: quotient, held until the next result is written.
- `rem`  out  WIDTH: remainder, held until the next result is written.
- `div_zero`  out  1: set with `done` when `din2` was 0; held with the result.

## Operation
- **States**
  - IDLE: `busy`=0; waiting for `start`.
  - RUN: 32 iterations, tracked by a 6-bit counter.
  - FIX: sign correction and output write.
  - DONE: `busy`=0, `done`=1 for exactly one cycle.
- **Transitions**
  - IDLE/DONE -> RUN on `start`.
  - DONE -> IDLE without `start`.
  - RUN -> FIX after iteration 32.
  - FIX -> DONE always.
- **Accept edge** (`start`=1 and `busy`=0):
  - Latch `sign` and the operand signs.
  - Latch magnitudes: |din1| and |din2| when `sign`=1, raw values when `sign`=0.
  - Clear the 33-bit partial remainder and the counter.
- **Iteration step** (one per RUN cycle):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude, using a 33-bit subtract.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- **FIX**
  - Quotient is negated when `sign`=1 and the operand signs differ.
  - Remainder is negated when `sign`=1 and the dividend was negative.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- **Divide by zero** (divisor latched as 0): iterations still run, so latency is fixed.
  - FIX forces `quot`=all ones and `rem`=the original `din1` (not its magnitude), signed or unsigned.
  - `div_zero`=1.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF, `sign`=1): `quot`=0x80000000, `rem`=0. This falls out of the magnitude path with no special case.
- **Start while busy**: `start` while `busy`=1 is ignored. The in-flight operation is not disturbed and no queueing occurs.
- **Operand changes**: changes on `din1`/`din2`/`sign` after the accept edge have no effect.

## Timing
- **Reset values**: state IDLE; `busy`=0, `done`=0, `quot`=0, `rem`=0, `div_zero`=0.
- **Reset mid-operation**: `rst` at any point, including mid-RUN, aborts the operation. No `done` is produced and the reset values above apply on the next cycle.
- **Accept edge E0**: `busy`=1 from the cycle after E0.
- **Iterations**: edges E1..E32.
- **Result write**: edge E33 (FIX -> DONE) writes `quot`/`rem`/`div_zero`. In the cycle after E33, `done`=1 and `busy`=0.
- **Latency**: fixed 33 cycles from acceptance to `done` for every operand pair, including divide by zero.
- **Back-to-back**: `start` during the DONE cycle is accepted. The next `done` follows 33 cycles later, so throughput is one division per 33 cycles.
- **Output hold**: `quot`/`rem`/`div_zero` change only at a FIX write or at reset. They remain stable through a following RUN.
- **`done` width**: never high for more than one consecutive cycle.

## Test plan
- **Unsigned basic**: unsigned 100 / 7, `start` for one cycle -> `done` exactly 33 cycles after the accept edge; `quot`=14, `rem`=2, `div_zero`=0. Then 0xFFFFFFFF / 1 -> `quot`=0xFFFFFFFF, `rem`=0.
- **Signed**:
  - -7 / 2 -> `quot`=0xFFFFFFFD (-3), `rem`=0xFFFFFFFF (-1).
  - 7 / -2 -> `quot`=0xFFFFFFFD, `rem`=1.
  - The same bits 0xFFFFFFF9 / 2 unsigned -> `quot`=0x7FFFFFFC, `rem`=1.
- **Corner cases**:
  - 5 / 0 (signed and unsigned) -> `quot`=0xFFFFFFFF, `rem`=5, `div_zero`=1.
  - Signed -5 / 0 -> `rem`=0xFFFFFFFB.
  - Signed 0x80000000 / 0xFFFFFFFF -> `quot`=0x80000000, `rem`=0.
- **Handshake**:
  - Pulse `start` with 9 / 3 at cycle 10 of a running 100 / 7 -> only 100 / 7 completes (14, 2), with no second `done`.
  - Back-to-back `start` in the DONE cycle with 9 / 3 -> `quot`=3, `rem`=0 exactly 33 cycles later.
- **Reset abort**: assert `rst` for one cycle at iteration 20 -> the next cycle shows `busy`=0, `quot`=0, `rem`=0, and `done` stays low; a fresh 100 / 7 afterwards completes normally.
- **Random sweep**: 10k random operand pairs with random `sign`, compared against a reference model -> all `quot`/`rem`/`div_zero` match; latency is always 33.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake and data bundle for the sequential divider.
// The master drives requests; the slave (the divider) returns results.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  modport master (
    output start, sign, din1, din2,
    input  busy, done, quot, rem, div_zero
  );

  modport slave (
    input  start, sign, din1, din2,
    output busy, done, quot, rem, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, RISC-V M semantics.
// Fixed latency: accept edge, WIDTH iterations, one fix-up edge, then a done pulse.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  div_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  state_t           state_r, state_s;
  logic [5:0]       cnt_r, cnt_s;
  logic [WIDTH:0]   acc_r, acc_s;
  logic [WIDTH-1:0] dvd_r, dvd_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic [WIDTH-1:0] orig_r, orig_s;
  logic             sign_r, sign_s;
  logic             neg1_r, neg1_s;
  logic             neg2_r, neg2_s;
  logic [WIDTH-1:0] quot_r, quot_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic             dz_r, dz_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;

  // Next-state, datapath step and output write decisions
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    dvd_s   = dvd_r;
    dvs_s   = dvs_r;
    orig_s  = orig_r;
    sign_s  = sign_r;
    neg1_s  = neg1_r;
    neg2_s  = neg2_r;
    quot_s  = quot_r;
    rem_s   = rem_r;
    dz_s    = dz_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    shift_s = {acc_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    trial_s = shift_s - {1'b0, dvs_r};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_s = ST_RUN;
          busy_s  = 1'b1;
          sign_s  = bus.sign;
          neg1_s  = bus.sign & bus.din1[WIDTH-1];
          neg2_s  = bus.sign & bus.din2[WIDTH-1];
          dvd_s   = magnitude(bus.din1, bus.sign);
          dvs_s   = magnitude(bus.din2, bus.sign);
          orig_s  = bus.din1;
          acc_s   = {(WIDTH+1){1'b0}};
          cnt_s   = 6'd0;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end
      ST_RUN: begin
        // A clear top bit of the trial result means the subtraction fit.
        if (!trial_s[WIDTH]) begin
          acc_s = trial_s;
          dvd_s = {dvd_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_s = shift_s;
          dvd_s = {dvd_r[WIDTH-2:0], 1'b0};
        end
        cnt_s = cnt_r + 6'd1;
        if (cnt_r == LAST_CNT) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        if (dvs_r == {WIDTH{1'b0}}) begin
          quot_s = {WIDTH{1'b1}};
          rem_s  = orig_r;
          dz_s   = 1'b1;
        end else begin
          quot_s = (sign_r && (neg1_r != neg2_r)) ? negate(dvd_r) : dvd_r;
          rem_s  = (sign_r && neg1_r) ? negate(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
          dz_s   = 1'b0;
        end
        state_s = ST_DONE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      acc_r   <= {(WIDTH+1){1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      orig_r  <= {WIDTH{1'b0}};
      sign_r  <= 1'b0;
      neg1_r  <= 1'b0;
      neg2_r  <= 1'b0;
      quot_r  <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      dz_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      dvd_r   <= dvd_s;
      dvs_r   <= dvs_s;
      orig_r  <= orig_s;
      sign_r  <= sign_s;
      neg1_r  <= neg1_s;
      neg2_r  <= neg2_s;
      quot_r  <= quot_s;
      rem_r   <= rem_s;
      dz_r    <= dz_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.quot     = quot_r;
  assign bus.rem      = rem_r;
  assign bus.div_zero = dz_r;

endmodule
